// File: rtl/fir_pkg.sv
// Shared types for the FIR sample feeder.
// State encoding, sample width and coefficient bundle.
package fir_pkg;

  localparam int SAMPLE_W = 8;
  localparam int FIR_TAPS = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // Index 0 = A, 1 = B, 2 = C
  typedef logic [FIR_TAPS-1:0][SAMPLE_W-1:0] coef_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Show-ahead sample FIFO for the FIR feeder.
// Flush has priority over push and pop.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [SAMPLE_W-1:0]          din_i,
  output logic [SAMPLE_W-1:0]          dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointers and occupancy; pointers wrap naturally
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Sample storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointer and count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered samples to the 3-tap FIR one at a time.
// Coefficients are swapped only while idle between samples.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [SAMPLE_W-1:0]    i_data,
  input  logic                   i_flush,
  input  logic                   i_coefValid,
  input  logic [SAMPLE_W-1:0]    i_a,
  input  logic [SAMPLE_W-1:0]    i_b,
  input  logic [SAMPLE_W-1:0]    i_c,
  output logic [SAMPLE_W-1:0]    o_x,
  output logic                   o_dataValid,
  output logic [SAMPLE_W-1:0]    o_a,
  output logic [SAMPLE_W-1:0]    o_b,
  output logic [SAMPLE_W-1:0]    o_c,
  input  logic                   i_done,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] x_q, x_d;
  coef_t               coef_q, coef_d;
  coef_t               pcoef_q, pcoef_d;
  logic                pend_q, pend_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                err_q, err_d;
  logic                rdy_q;
  logic                issue;
  logic                full;
  logic                empty;
  logic [SAMPLE_W-1:0] head;

  fir_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_arst_n),
    .push_i  (i_valid && o_ready),
    .pop_i   (issue),
    .flush_i (i_flush),
    .din_i   (i_data),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (o_level)
  );

  assign o_ready     = rdy_q && !full;
  assign o_dataValid = (state_q == ISSUE);
  assign o_x         = x_q;
  assign o_a         = coef_q[0];
  assign o_b         = coef_q[1];
  assign o_c         = coef_q[2];
  assign o_err       = err_q;

  // Issue FSM, wait timer and coefficient pending/commit
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    coef_d  = coef_q;
    pcoef_d = pcoef_q;
    pend_d  = pend_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    issue   = 1'b0;
    if (i_coefValid) begin
      pcoef_d = {i_c, i_b, i_a};
      pend_d  = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          coef_d = pcoef_q;
          pend_d = i_coefValid;
        end else if (!empty) begin
          state_d = ISSUE;
          x_d     = head;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmr_d   = '0;
      end
      WAIT: begin
        if (i_done) begin
          state_d = IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      coef_q  <= '0;
      pcoef_q <= '0;
      pend_q  <= 1'b0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      coef_q  <= coef_d;
      pcoef_q <= pcoef_d;
      pend_q  <= pend_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder.
// Directed scenarios plus a randomized run against a queue model.
module tb_fir_sample_feeder;
  import fir_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_data = '0;
  logic       i_flush = 1'b0;
  logic       i_coefValid = 1'b0;
  logic [7:0] i_a = '0, i_b = '0, i_c = '0;
  logic [7:0] o_x;
  logic       o_dataValid;
  logic [7:0] o_a, o_b, o_c;
  logic       i_done = 1'b0;
  logic [3:0] o_level;
  logic       o_err;

  int total = 0;
  int bad = 0;
  byte unsigned sb[$];
  logic [23:0] exp_coef = '0;
  bit  stall = 1'b0;
  bit  armed = 1'b0;
  int  cnt = 0;
  bit  prev_dv = 1'b0;

  always #5 clk = ~clk;

  fir_sample_feeder #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_arst_n    (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_flush     (i_flush),
    .i_coefValid (i_coefValid),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_c         (i_c),
    .o_x         (o_x),
    .o_dataValid (o_dataValid),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_c         (o_c),
    .i_done      (i_done),
    .o_level     (o_level),
    .o_err       (o_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every issued sample must match the head of the scoreboard
  initial begin
    byte unsigned e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_dv = 1'b0;
      end else begin
        if (o_dataValid) begin
          chk("pulse_width", 32'(prev_dv), 0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue: got x=%0h want none", o_x);
          end else begin
            e = sb.pop_front();
            chk("x_order", 32'(o_x), 32'(e));
            chk("coef_at_issue", 32'({o_a, o_b, o_c}), 32'(exp_coef));
          end
        end
        prev_dv = o_dataValid;
      end
    end
  end

  // FIR model: i_done some cycles after each pulse, held off by stall
  initial begin
    forever begin
      @(negedge clk);
      #1;
      i_done = 1'b0;
      if (!rst_n) begin
        armed = 1'b0;
      end else if (o_dataValid) begin
        armed = 1'b1;
        cnt = $urandom_range(1, 6);
      end else if (armed) begin
        if (cnt > 1) cnt--;
        else if (!stall) begin
          i_done = 1'b1;
          armed = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input byte unsigned d, input bit acc);
    i_valid = 1'b1;
    i_data = d;
    chk("ready_on_push", 32'(o_ready), 32'(acc));
    if (acc) sb.push_back(d);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic set_coef(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    i_coefValid = 1'b1;
    i_a = a;
    i_b = b;
    i_c = c;
    @(negedge clk);
    i_coefValid = 1'b0;
  endtask

  task automatic wait_pulse(input int lim);
    int n = 0;
    while (!o_dataValid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_seen", 32'(o_dataValid), 1);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((sb.size() != 0 || armed || o_dataValid) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(sb.size() == 0 && !armed && !o_dataValid), 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_x"}, 32'(o_x), 0);
    chk({nm, "_dv"}, 32'(o_dataValid), 0);
    chk({nm, "_coef"}, 32'({o_a, o_b, o_c}), 0);
    chk({nm, "_level"}, 32'(o_level), 0);
    chk({nm, "_err"}, 32'(o_err), 0);
    chk({nm, "_ready"}, 32'(o_ready), 0);
  endtask

  initial begin
    int np;
    cyc(2);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(1);
    chk("ready_after_release", 32'(o_ready), 1);

    // single sample latency
    push(8'h10, 1'b1);
    chk("single_dv_early", 32'(o_dataValid), 0);
    chk("single_level", 32'(o_level), 1);
    cyc(1);
    chk("single_dv", 32'(o_dataValid), 1);
    chk("single_x", 32'(o_x), 32'h10);
    chk("single_level_pop", 32'(o_level), 0);
    drain(40);
    chk("x_holds", 32'(o_x), 32'h10);

    // burst to full behind a stalled FIR
    stall = 1'b1;
    push(8'hA0, 1'b1);
    wait_pulse(5);
    cyc(1);
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
    chk("burst_level_full", 32'(o_level), 8);
    push(8'hEE, 1'b0);
    chk("burst_level_hold", 32'(o_level), 8);
    stall = 1'b0;
    cyc(1);
    chk("burst_dv_idle", 32'(o_dataValid), 0);
    cyc(1);
    chk("burst_dv", 32'(o_dataValid), 1);
    chk("burst_level_pop", 32'(o_level), 7);
    drain(200);
    chk("burst_ready_back", 32'(o_ready), 1);

    // coefficient update during WAIT
    stall = 1'b1;
    push(8'h21, 1'b1);
    push(8'h22, 1'b1);
    wait_pulse(5);
    cyc(1);
    set_coef(8'd1, 8'd2, 8'd3);
    exp_coef = 24'h010203;
    repeat (4) begin
      chk("coef_held", 32'({o_a, o_b, o_c}), 0);
      cyc(1);
    end
    stall = 1'b0;
    cyc(1);
    chk("coef_pre_commit", 32'({o_a, o_b, o_c}), 0);
    chk("coef_dv_idle1", 32'(o_dataValid), 0);
    cyc(1);
    chk("coef_commit", 32'({o_a, o_b, o_c}), 32'h010203);
    chk("coef_dv_idle2", 32'(o_dataValid), 0);
    cyc(1);
    chk("coef_next_issue", 32'(o_dataValid), 1);
    chk("coef_next_x", 32'(o_x), 32'h22);
    drain(60);

    // flush with a simultaneous push at level 3
    stall = 1'b1;
    push(8'h30, 1'b1);
    wait_pulse(5);
    push(8'h31, 1'b1);
    push(8'h32, 1'b1);
    push(8'h33, 1'b1);
    chk("flush_level3", 32'(o_level), 3);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data = 8'h77;
    cyc(1);
    i_flush = 1'b0;
    i_valid = 1'b0;
    sb.delete();
    chk("flush_level0", 32'(o_level), 0);
    stall = 1'b0;
    np = 0;
    repeat (12) begin
      cyc(1);
      np += int'(o_dataValid);
    end
    chk("flush_no_issue", 32'(np), 0);
    chk("flush_level_stays", 32'(o_level), 0);
    drain(20);

    // timeout path
    stall = 1'b1;
    push(8'h40, 1'b1);
    push(8'h41, 1'b1);
    wait_pulse(5);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cyc(1);
      chk("err_before_timeout", 32'(o_err), 0);
    end
    cyc(1);
    chk("err_set", 32'(o_err), 1);
    chk("timeout_dv_idle", 32'(o_dataValid), 0);
    stall = 1'b0;
    cyc(1);
    chk("timeout_next_issue", 32'(o_dataValid), 1);
    chk("timeout_next_x", 32'(o_x), 32'h41);
    drain(40);

    // randomized traffic with coefficient reloads
    for (int i = 0; i < 300; i++) begin
      if (sb.size() < 6 && $urandom_range(0, 2) == 0) begin
        push(8'($urandom), 1'b1);
      end else if (armed && $urandom_range(0, 3) == 0) begin
        logic [23:0] r;
        r = 24'($urandom);
        set_coef(r[23:16], r[15:8], r[7:0]);
        exp_coef = r;
      end else begin
        cyc(1);
      end
    end
    drain(300);
    chk("err_sticky", 32'(o_err), 1);

    // reset in WAIT with four samples queued
    stall = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i), 1'b1);
    chk("rst_level4", 32'(o_level), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    sb.delete();
    exp_coef = '0;
    stall = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_level", 32'(o_level), 0);
    np = 0;
    repeat (10) begin
      cyc(1);
      np += int'(o_dataValid);
    end
    chk("rst_no_issue", 32'(np), 0);
    push(8'h60, 1'b1);
    drain(40);
    chk("rst_last_x", 32'(o_x), 32'h60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
